vedic8x8_seq_ctrl: RTL and testbench

Sequencing controller that computes an 8x8 unsigned product using one shared 4x4 Vedic multiplier core (array4_4), time-multiplexed over four partial-product steps. Operands enter and the result leaves through valid/ready handshakes. The block is the reuse path for the 4x4 core wherever an 8-bit product is needed and area matters more than throughput.

---
 rtl/vedic8x8_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_vedic8x8_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic8x8_seq_ctrl.sv
// vedic8x8_seq_ctrl: 8x8 unsigned multiplier built from one shared 4x4 Vedic
// core, time-multiplexed over four nibble partial products.
//
// Handshake rules (both ports):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   in_ready is 1 only in IDLE. out_valid is 1 only in DONE, and prod holds
//   steady until out_ready is seen high. Neither ready depends combinationally
//   on the matching valid.

// array4_4: 4x4 Urdhva-Tiryagbhyam (vertical and crosswise) multiplier.
// Each column sums the bit-products whose indices add to that column's
// weight. The columns are then added with their weights.
module array4_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [2:0] c0, c1, c2, c3, c4, c5, c6;

  assign c0 = {2'b00, a[0] & b[0]};
  assign c1 = {2'b00, a[1] & b[0]} + {2'b00, a[0] & b[1]};
  assign c2 = {2'b00, a[2] & b[0]} + {2'b00, a[1] & b[1]} + {2'b00, a[0] & b[2]};
  assign c3 = {2'b00, a[3] & b[0]} + {2'b00, a[2] & b[1]} +
              {2'b00, a[1] & b[2]} + {2'b00, a[0] & b[3]};
  assign c4 = {2'b00, a[3] & b[1]} + {2'b00, a[2] & b[2]} + {2'b00, a[1] & b[3]};
  assign c5 = {2'b00, a[3] & b[2]} + {2'b00, a[2] & b[3]};
  assign c6 = {2'b00, a[3] & b[3]};

  assign p = {5'b0, c0}
           + ({5'b0, c1} << 1)
           + ({5'b0, c2} << 2)
           + ({5'b0, c3} << 3)
           + ({5'b0, c4} << 4)
           + ({5'b0, c5} << 5)
           + ({5'b0, c6} << 6);
endmodule

module vedic8x8_seq_ctrl #(
  parameter int OP_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     prod,
  output logic            busy
);
  // The nibble split below only works for exactly two 4-bit halves.
  generate
    if (OP_W != 8) begin : g_bad_width
      $error("vedic8x8_seq_ctrl: OP_W must be 8");
    end
  endgenerate

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  step;
  logic [15:0] acc;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [3:0]  core_a;
  logic [3:0]  core_b;
  logic [7:0]  core_p;
  logic [15:0] pp_shifted;

  // Step bit 0 selects the high nibble of a, step bit 1 the high nibble of b.
  assign core_a = step[0] ? a_q[7:4] : a_q[3:0];
  assign core_b = step[1] ? b_q[7:4] : b_q[3:0];

  array4_4 u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  // Position the partial product by the combined nibble weight of its operands.
  always_comb begin
    pp_shifted = {8'h00, core_p};
    case (step)
      2'd0:    pp_shifted = {8'h00, core_p};
      2'd1,
      2'd2:    pp_shifted = {4'h0, core_p, 4'h0};
      default: pp_shifted = {core_p, 8'h00};
    endcase
  end

  // Control FSM plus operand capture and accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 2'd0;
      acc   <= 16'h0000;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= 16'h0000;
            step  <= 2'd0;
            state <= MUL;
          end
        end
        MUL: begin
          acc  <= acc + pp_shifted;
          step <= step + 2'd1;
          if (step == 2'd3) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign prod      = acc;
endmodule

// File: tb/tb_vedic8x8_seq_ctrl.sv
// tb_vedic8x8_seq_ctrl: directed and random checks of the sequential 8x8
// multiplier against an arithmetic reference model.
module tb_vedic8x8_seq_ctrl;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;
  logic        busy;

  int checks;
  int failures;
  logic [15:0] exp_q[$];

  vedic8x8_seq_ctrl #(.OP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic product
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int r;
    r = int'(x) * int'(y);
    return r[15:0];
  endfunction

  // Reference partial sum after k+1 nibble steps (order: lo*lo, hi*lo, lo*hi, hi*hi)
  function automatic logic [15:0] ref_partial(input logic [7:0] x, input logic [7:0] y, input int k);
    int xs[4];
    int ys[4];
    int sh[4];
    int s;
    xs = '{int'(x[3:0]), int'(x[7:4]), int'(x[3:0]), int'(x[7:4])};
    ys = '{int'(y[3:0]), int'(y[3:0]), int'(y[7:4]), int'(y[7:4])};
    sh = '{1, 16, 16, 256};
    s = 0;
    for (int i = 0; i <= k; i++) s = s + xs[i] * ys[i] * sh[i];
    return s[15:0];
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: one full transaction with latency and result checks
  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input string tag);
    int n;
    logic [15:0] e;
    e = ref_mul(xa, xb);
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin tick; n++; end
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    check_int({tag, "_latency"}, n, 4);
    check16({tag, "_prod"}, prod, e);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check1({tag, "_ov_clear"}, out_valid, 1'b0);
  endtask

  // Directed sequence, then random streaming, then report
  initial begin
    logic [15:0] held;
    logic [15:0] e;
    int cyc;
    int next_acc;
    int accepted;
    logic exp_acc;

    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    tick; tick;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check16("rst_prod", prod, 16'h0000);
    rst_n = 1'b1;
    tick;

    // Nominal with per-step accumulator
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check1("nom_in_ready_mul", in_ready, 1'b0);
    check1("nom_busy_mul", busy, 1'b1);
    check16("nom_acc_cleared", prod, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      tick;
      check16($sformatf("nom_acc_step%0d", k), prod, ref_partial(8'h12, 8'h34, k));
      check1($sformatf("nom_ov_step%0d", k), out_valid, (k == 3));
    end
    check16("nom_final", prod, 16'h03A8);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check1("nom_idle_busy", busy, 1'b0);

    // Corner values
    run_op(8'hFF, 8'hFF, "ffff");
    run_op(8'h00, 8'hA5, "zero");
    run_op(8'hFF, 8'h01, "ff01");

    // Operand isolation: change inputs after the accept edge
    a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
    tick;
    a = 8'hFF; b = 8'hFF;
    for (int k = 0; k < 4; k++) tick;
    check1("iso_ov", out_valid, 1'b1);
    check16("iso_prod", prod, 16'h0E10);
    check1("iso_in_ready", in_ready, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Backpressure with pending input traffic
    a = 8'h9C; b = 8'h47; in_valid = 1'b1;
    e = ref_mul(8'h9C, 8'h47);
    tick;
    for (int k = 0; k < 4; k++) tick;
    held = e;
    for (int k = 0; k < 10; k++) begin
      a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      tick;
      check16($sformatf("bp_prod_hold%0d", k), prod, held);
      check1($sformatf("bp_in_ready%0d", k), in_ready, 1'b0);
      check1($sformatf("bp_ov%0d", k), out_valid, 1'b1);
    end
    a = 8'h5A; b = 8'hC3; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check1("bp_idle_busy", busy, 1'b0);
    check1("bp_idle_in_ready", in_ready, 1'b1);
    check1("bp_idle_ov", out_valid, 1'b0);
    tick;
    in_valid = 1'b0;
    check1("bp_pending_accepted", busy, 1'b1);
    for (int k = 0; k < 4; k++) tick;
    check1("bp_pending_ov", out_valid, 1'b1);
    check16("bp_pending_prod", prod, ref_mul(8'h5A, 8'hC3));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Asynchronous reset in MUL step 2
    a = 8'hAB; b = 8'hCD; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    #2 rst_n = 1'b0;
    #1;
    check1("mid_rst_ov", out_valid, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_in_ready", in_ready, 1'b1);
    check16("mid_rst_prod", prod, 16'h0000);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      check1($sformatf("post_rst_ov%0d", k), out_valid, 1'b0);
    end
    check16("post_rst_prod", prod, 16'h0000);

    // Streaming: 1000 random pairs, in_valid and out_ready held high
    cyc = 0; next_acc = 0; accepted = 0;
    out_ready = 1'b1;
    while ((accepted < 1000 || exp_q.size() > 0) && cyc < 7000) begin
      if (accepted < 1000) begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        in_valid = 1'b1;
        exp_acc = (cyc == next_acc);
        check1("stream_in_ready", in_ready, exp_acc);
        check1("stream_busy", busy, !exp_acc);
        if (in_ready) begin
          exp_q.push_back(ref_mul(a, b));
          accepted++;
          next_acc = cyc + 6;
        end
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (exp_q.size() > 0) check16("stream_prod", prod, exp_q.pop_front());
        else check1("stream_unexpected_out", out_valid, 1'b0);
      end
      tick;
      cyc++;
    end
    check_int("stream_accepted", accepted, 1000);
    check_int("stream_drained", exp_q.size(), 0);
    out_ready = 1'b0;
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
